// File: rtl/neck_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neck_pkg
// Description : Shared types and helpers for the neck detector. Holds the FSM
//               state encoding, the judge mode encodings and a signed
//               saturation helper used by the difference chain.
// Revision    : 1.0 - initial release
// ============================================================================
package neck_pkg;

    // FSM state, also exported on the debug 'state' port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        CUT     = 2'd2,
        BLANK   = 2'd3
    } neck_state_e;

    // Judge modes; 2'b11 behaves exactly like 2'b10
    localparam logic [1:0] c_mode_d1       = 2'b00;
    localparam logic [1:0] c_mode_d12      = 2'b01;
    localparam logic [1:0] c_mode_d123     = 2'b10;
    localparam logic [1:0] c_mode_d123_alt = 2'b11;

    // Fill level at which the difference history is fully populated
    localparam logic [2:0] c_fill_full = 3'd4;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    // Valid for w in 2..31; the caller truncates the result to w bits.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage : neck_pkg
`default_nettype wire

// File: rtl/neck_dif_sat.sv
`default_nettype none
// ============================================================================
// Module      : neck_dif_sat
// Description : Three-stage saturated difference chain. On every en_sample it
//               forms d1 = x[n]-x[n-1], d2 = d1[n]-d1[n-1], d3 = d2[n]-d2[n-1]
//               at DATA_W+1 bits, clamps each to DATA_W bits and keeps the
//               clamped values as history. A fill counter (saturating at 4)
//               marks when the history is complete enough to judge.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               en_sample         - one-cycle strobe, sample_data valid
//               sample_data       - signed input sample
//               d1, d2, d3        - registered saturated differences
//               dif_valid         - one-cycle pulse, d1..d3 updated
//               judge_valid       - accompanies dif_valid when history full
// Revision    : 1.0 - initial release
// ============================================================================
module neck_dif_sat
    import neck_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_sample,
    input  logic signed [DATA_W-1:0] sample_data,
    output logic signed [DATA_W-1:0] d1,
    output logic signed [DATA_W-1:0] d2,
    output logic signed [DATA_W-1:0] d3,
    output logic                     dif_valid,
    output logic                     judge_valid
);

    logic signed [DATA_W-1:0] x_prev_q, x_prev_d;
    logic signed [DATA_W-1:0] d1_q, d1_d;
    logic signed [DATA_W-1:0] d2_q, d2_d;
    logic signed [DATA_W-1:0] d3_q, d3_d;
    logic [2:0]               fill_q, fill_d;
    logic                     dif_valid_q, dif_valid_d;
    logic                     judge_valid_q, judge_valid_d;

    logic signed [DATA_W:0]   w_d1_wide, w_d2_wide, w_d3_wide;
    logic signed [DATA_W-1:0] w_d1_sat, w_d2_sat, w_d3_sat;

    // Each stage subtracts at one extra bit so the true difference is never
    // lost before clamping; the next stage works from the clamped value.
    always_comb begin
        w_d1_wide = {sample_data[DATA_W-1], sample_data} - {x_prev_q[DATA_W-1], x_prev_q};
        w_d1_sat  = DATA_W'(sat_signed(32'(w_d1_wide), DATA_W));
        w_d2_wide = {w_d1_sat[DATA_W-1], w_d1_sat} - {d1_q[DATA_W-1], d1_q};
        w_d2_sat  = DATA_W'(sat_signed(32'(w_d2_wide), DATA_W));
        w_d3_wide = {w_d2_sat[DATA_W-1], w_d2_sat} - {d2_q[DATA_W-1], d2_q};
        w_d3_sat  = DATA_W'(sat_signed(32'(w_d3_wide), DATA_W));
    end

    always_comb begin
        x_prev_d      = x_prev_q;
        d1_d          = d1_q;
        d2_d          = d2_q;
        d3_d          = d3_q;
        fill_d        = fill_q;
        dif_valid_d   = en_sample;
        // Judging needs four samples of history already in place
        judge_valid_d = en_sample && (fill_q == c_fill_full);
        if (en_sample) begin
            x_prev_d = sample_data;
            d1_d     = w_d1_sat;
            d2_d     = w_d2_sat;
            d3_d     = w_d3_sat;
            if (fill_q != c_fill_full) begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_q      <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            d3_q          <= '0;
            fill_q        <= '0;
            dif_valid_q   <= 1'b0;
            judge_valid_q <= 1'b0;
        end else begin
            x_prev_q      <= x_prev_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            d3_q          <= d3_d;
            fill_q        <= fill_d;
            dif_valid_q   <= dif_valid_d;
            judge_valid_q <= judge_valid_d;
        end
    end

    assign d1          = d1_q;
    assign d2          = d2_q;
    assign d3          = d3_q;
    assign dif_valid   = dif_valid_q;
    assign judge_valid = judge_valid_q;

endmodule : neck_dif_sat
`default_nettype wire

// File: rtl/neck_detector.sv
`default_nettype none
// ============================================================================
// Module      : neck_detector
// Description : Neck judge for the welder control chain. Builds saturated
//               1st/2nd/3rd-order differences of filtered samples, qualifies
//               each judged sample against runtime thresholds in the selected
//               mode, declares a neck after CONFIRM_N consecutive hits, then
//               cuts welder power for HOLD_CYCLES clocks followed by a
//               BLANK_CYCLES judging blackout.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               en_sample         - one-cycle strobe, sample_data valid
//               sample_data       - signed filtered sample
//               arm               - level, 1 = detection enabled
//               mode              - 00 d1, 01 d1&d2, 1x d1&d2&d3
//               thr1..thr3        - signed strict thresholds
//               d1..d3, dif_valid - registered differences and update pulse
//               neck_flag         - one-cycle pulse on neck declaration
//               power_switch      - 1 = welder power on
//               state             - FSM state (debug)
//               neck_count        - saturating neck event count
// Config      : NECK_DET_STATS_EN - when defined, neck_count counts events;
//               otherwise neck_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module neck_detector
    import neck_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int CONFIRM_N    = 3,
    parameter int HOLD_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_sample,
    input  logic signed [DATA_W-1:0] sample_data,
    input  logic                     arm,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] thr1,
    input  logic signed [DATA_W-1:0] thr2,
    input  logic signed [DATA_W-1:0] thr3,
    output logic signed [DATA_W-1:0] d1,
    output logic signed [DATA_W-1:0] d2,
    output logic signed [DATA_W-1:0] d3,
    output logic                     dif_valid,
    output logic                     neck_flag,
    output logic                     power_switch,
    output logic [1:0]               state,
    output logic [15:0]              neck_count
);

    localparam int c_tmr_max = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam int c_hit_w   = $clog2(CONFIRM_N + 1);

    // Timers count down to zero, so a window of N clocks loads N-1
    localparam logic [c_tmr_w-1:0] c_hold_load  = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_blank_load = c_tmr_w'(BLANK_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one    = c_tmr_w'(1);
    localparam logic [c_hit_w-1:0] c_hit_last   = c_hit_w'(CONFIRM_N - 1);
    localparam logic [c_hit_w-1:0] c_hit_full   = c_hit_w'(CONFIRM_N);
    localparam logic [c_hit_w-1:0] c_hit_one    = c_hit_w'(1);

    logic w_judge_valid;
    logic w_judge;
    logic w_q1, w_q2, w_q3;
    logic w_qualify;

    neck_state_e               state_q, state_d;
    logic [c_hit_w-1:0]        hit_q, hit_d;
    logic [c_tmr_w-1:0]        timer_q, timer_d;
    logic                      power_q, power_d;
    logic                      neck_flag_q, neck_flag_d;

    neck_dif_sat #(
        .DATA_W (DATA_W)
    ) u_dif (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_sample   (en_sample),
        .sample_data (sample_data),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .dif_valid   (dif_valid),
        .judge_valid (w_judge_valid)
    );

    // The judge looks at the freshly registered differences in the cycle
    // they appear, so its verdict lands one clock after dif_valid.
    assign w_judge = dif_valid && w_judge_valid;
    assign w_q1    = d1 > thr1;
    assign w_q2    = d2 > thr2;
    assign w_q3    = d3 > thr3;

    always_comb begin
        case (mode)
            c_mode_d1:   w_qualify = w_q1;
            c_mode_d12:  w_qualify = w_q1 && w_q2;
            default:     w_qualify = w_q1 && w_q2 && w_q3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        timer_d     = timer_q;
        power_d     = power_q;
        neck_flag_d = 1'b0;
        if (!arm) begin
            // Disarming wins in every state, including mid-cut
            state_d = IDLE;
            hit_d   = '0;
            timer_d = '0;
            power_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = MONITOR;
                    hit_d   = '0;
                    power_d = 1'b1;
                end
                MONITOR: begin
                    power_d = 1'b1;
                    if (w_judge) begin
                        if (w_qualify) begin
                            if (hit_q == c_hit_last) begin
                                state_d     = CUT;
                                hit_d       = c_hit_full;
                                timer_d     = c_hold_load;
                                power_d     = 1'b0;
                                neck_flag_d = 1'b1;
                            end else begin
                                hit_d = hit_q + c_hit_one;
                            end
                        end else begin
                            hit_d = '0;
                        end
                    end
                end
                CUT: begin
                    power_d = 1'b0;
                    if (timer_q == '0) begin
                        state_d = BLANK;
                        timer_d = c_blank_load;
                        power_d = 1'b1;
                        hit_d   = '0;
                    end else begin
                        timer_d = timer_q - c_tmr_one;
                    end
                end
                BLANK: begin
                    power_d = 1'b1;
                    hit_d   = '0;
                    if (timer_q == '0) begin
                        state_d = MONITOR;
                    end else begin
                        timer_d = timer_q - c_tmr_one;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hit_d   = '0;
                    timer_d = '0;
                    power_d = 1'b1;
                end
            endcase
        end
    end

`ifdef NECK_DET_STATS_EN
    logic [15:0] count_q, count_d;

    // Counts with the flag being raised so the two appear on the same clock
    always_comb begin
        count_d = count_q;
        if (neck_flag_d && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    assign neck_count = count_q;
`else
    assign neck_count = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hit_q       <= '0;
            timer_q     <= '0;
            power_q     <= 1'b1;
            neck_flag_q <= 1'b0;
`ifdef NECK_DET_STATS_EN
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            timer_q     <= timer_d;
            power_q     <= power_d;
            neck_flag_q <= neck_flag_d;
`ifdef NECK_DET_STATS_EN
            count_q     <= count_d;
`endif
        end
    end

    assign neck_flag    = neck_flag_q;
    assign power_switch = power_q;
    assign state        = state_q;

endmodule : neck_detector
`default_nettype wire

// File: tb/tb_neck_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_neck_detector
// Description : Self-checking bench for neck_detector. A behavioural model
//               derives expected differences and neck events from the sample
//               stream; expected responses are queued and a monitor pops and
//               compares them whenever the DUT presents an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neck_detector;

    localparam int DW    = 12;
    localparam int CN    = 3;
    localparam int HOLD  = 20;
    localparam int BLANK = 15;
    localparam int XMAX  = (1 << (DW - 1)) - 1;
    localparam int XMIN  = -(1 << (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en_sample = 1'b0;
    logic signed [DW-1:0] sample_data = '0;
    logic                 arm = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic signed [DW-1:0] thr1 = '0, thr2 = '0, thr3 = '0;
    logic signed [DW-1:0] d1, d2, d3;
    logic                 dif_valid, neck_flag, power_switch;
    logic [1:0]           state;
    logic [15:0]          neck_count;

    neck_detector #(
        .DATA_W(DW), .CONFIRM_N(CN), .HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_sample(en_sample), .sample_data(sample_data),
        .arm(arm), .mode(mode), .thr1(thr1), .thr2(thr2), .thr3(thr3),
        .d1(d1), .d2(d2), .d3(d3), .dif_valid(dif_valid), .neck_flag(neck_flag),
        .power_switch(power_switch), .state(state), .neck_count(neck_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_necks = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int a; int b; int c; } dexp_t;
    dexp_t dq[$];
    int    nq[$];

    int ecount = 0;
    int m_phase = 0, m_rem = 0, m_hit = 0, m_ps = 1, m_count = 0;
    int m_xp = 0, m_d1p = 0, m_d2p = 0, m_n = 0;
    bit m_pv = 0, m_pj = 0;
    int m_pd1 = 0, m_pd2 = 0, m_pd3 = 0;

    function automatic int clamp(input int v);
        if (v > XMAX) return XMAX;
        if (v < XMIN) return XMIN;
        return v;
    endfunction

    function automatic bit qualifies(input int a, input int b, input int c);
        bit r1, r2, r3;
        r1 = a > int'(thr1);
        r2 = b > int'(thr2);
        r3 = c > int'(thr3);
        if (mode == 2'b00) return r1;
        if (mode == 2'b01) return r1 && r2;
        return r1 && r2 && r3;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_hit = 0; m_ps = 1; m_count = 0;
        m_xp = 0; m_d1p = 0; m_d2p = 0; m_n = 0;
        m_pv = 0; m_pj = 0;
        dq.delete();
        nq.delete();
    endtask

    task automatic model_step();
        bit nf;
        int x, a, b, c;
        nf = 0;
        // phase: 0 idle, 1 monitor, 2 cut, 3 blank; m_rem = clocks left
        if (!arm) begin
            m_phase = 0; m_hit = 0; m_rem = 0; m_ps = 1;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_hit = 0; end
                1: if (m_pv && m_pj) begin
                       if (qualifies(m_pd1, m_pd2, m_pd3)) begin
                           m_hit++;
                           if (m_hit >= CN) begin
                               m_phase = 2; m_rem = HOLD; m_ps = 0; nf = 1;
                               if (m_count < 65535) m_count++;
                           end
                       end else begin
                           m_hit = 0;
                       end
                   end
                2: begin
                       m_rem--;
                       if (m_rem == 0) begin m_phase = 3; m_rem = BLANK; m_ps = 1; m_hit = 0; end
                   end
                default: begin
                       m_rem--;
                       if (m_rem == 0) m_phase = 1;
                   end
            endcase
        end
        // sample arriving at this edge becomes the next judge candidate
        m_pv = en_sample;
        if (en_sample) begin
            x = int'(sample_data);
            a = clamp(x - m_xp);
            b = clamp(a - m_d1p);
            c = clamp(b - m_d2p);
            m_pj = (m_n >= 4);
            m_n++;
            m_xp = x; m_d1p = a; m_d2p = b;
            m_pd1 = a; m_pd2 = b; m_pd3 = c;
            dq.push_back('{a: a, b: b, c: c});
        end
        if (nf) nq.push_back(ecount);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk && rst_n) ecount++;
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        dexp_t e;
        int    stamp;
        forever begin
            @(negedge clk);
            if (dif_valid) begin
                if (dq.size() == 0) begin
                    chk("dif_unexpected", 1, 0);
                end else begin
                    e = dq.pop_front();
                    chk("d1", int'(d1), e.a);
                    chk("d2", int'(d2), e.b);
                    chk("d3", int'(d3), e.c);
                end
            end else if (dq.size() != 0) begin
                chk("dif_missing", 0, 1);
                void'(dq.pop_front());
            end
            if (neck_flag) begin
                n_necks++;
                if (nq.size() == 0) begin
                    chk("neck_unexpected", 1, 0);
                end else begin
                    stamp = nq.pop_front();
                    chk("neck_cycle", ecount, stamp);
                end
            end else if (nq.size() != 0 && nq[0] <= ecount) begin
                stamp = nq.pop_front();
                chk("neck_missing", -1, stamp);
            end
            chk("power_switch", int'(power_switch), m_ps);
            chk("state", int'(state), m_phase);
`ifdef NECK_DET_STATS_EN
            chk("neck_count", int'(neck_count), m_count);
`else
            chk("neck_count", int'(neck_count), 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en_sample = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int x);
        en_sample   = 1'b1;
        sample_data = DW'(x);
        tick();
    endtask

    task automatic do_reset();
        en_sample = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic set_cfg(input int md, input int t1, input int t2, input int t3);
        mode = 2'(md);
        thr1 = DW'(t1);
        thr2 = DW'(t2);
        thr3 = DW'(t3);
    endtask

    int base_necks;
    int x;
    int exp_cnt;

    initial begin
        do_reset();
        chk("rst_d1", int'(d1), 0);
        chk("rst_d2", int'(d2), 0);
        chk("rst_d3", int'(d3), 0);
        chk("rst_dif_valid", int'(dif_valid), 0);
        chk("rst_neck_flag", int'(neck_flag), 0);
        chk("rst_power", int'(power_switch), 1);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(neck_count), 0);

        // constant input never qualifies against thr1 = 0
        set_cfg(0, 0, 0, 0); arm = 1'b1; idle(2);
        base_necks = n_necks;
        for (int i = 0; i < 12; i++) send(100);
        idle(5);
        chk("const_necks", n_necks - base_necks, 0);
        chk("const_d1", int'(d1), 0);
        chk("const_power", int'(power_switch), 1);

        // ramp: neck on 7th sample, then full CUT and BLANK
        do_reset(); set_cfg(0, 5, 0, 0); arm = 1'b1; idle(2);
        base_necks = n_necks;
        for (int i = 0; i < 12; i++) send(10 * i);
        idle(HOLD + BLANK + 10);
        chk("ramp_necks", n_necks - base_necks, 1);
        chk("ramp_state_after", int'(state), 1);

        // squares: d2 = 2 qualifies with thr2 = 1, not with thr2 = 2
        do_reset(); set_cfg(1, 0, 1, 0); arm = 1'b1; idle(2);
        base_necks = n_necks;
        for (int n = 1; n <= 10; n++) send(n * n);
        idle(HOLD + BLANK + 5);
        chk("sq_thr1_necks", n_necks - base_necks, 1);
        do_reset(); set_cfg(1, 0, 2, 0); arm = 1'b1; idle(2);
        base_necks = n_necks;
        for (int n = 1; n <= 10; n++) send(n * n);
        idle(5);
        chk("sq_thr2_necks", n_necks - base_necks, 0);

        // saturation at both rails
        do_reset(); arm = 1'b0;
        send(-2048); send(2047); idle(1);
        chk("sat_hi_d1", int'(d1), 2047);
        send(-2048); idle(1);
        chk("sat_lo_d1", int'(d1), -2048);

        // two hits, one failing judged sample, then three hits
        do_reset(); set_cfg(0, 5, 0, 0); arm = 1'b1; idle(2);
        base_necks = n_necks;
        send(0); send(10); send(20); send(30); send(40); send(50); send(50);
        send(60); send(70); idle(4);
        chk("interrupt_no_neck", n_necks - base_necks, 0);
        send(80); idle(4);
        chk("interrupt_neck", n_necks - base_necks, 1);
        idle(HOLD + BLANK);

        // arm dropped mid-cut, then re-armed
        do_reset(); set_cfg(0, 5, 0, 0); arm = 1'b1; idle(2);
        for (int i = 0; i < 7; i++) send(10 * i);
        idle(4);
        chk("drop_in_cut", int'(state), 2);
        arm = 1'b0; tick();
        chk("drop_power", int'(power_switch), 1);
        chk("drop_state", int'(state), 0);
`ifdef NECK_DET_STATS_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("drop_count", int'(neck_count), exp_cnt);
        arm = 1'b1; idle(2);
        chk("rearm_state", int'(state), 1);
        base_necks = n_necks;
        send(70); send(80); send(90); idle(3);
        chk("rearm_neck", n_necks - base_necks, 1);
        idle(HOLD + BLANK);

        // asynchronous reset while power is cut
        do_reset(); set_cfg(0, 5, 0, 0); arm = 1'b1; idle(2);
        for (int i = 0; i < 7; i++) send(10 * i);
        idle(3);
        chk("areset_pre_power", int'(power_switch), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_power", int'(power_switch), 1);
        chk("areset_state", int'(state), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized walk with occasional config and arm changes
        do_reset(); set_cfg(0, 5, 3, 0); arm = 1'b1;
        x = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc % 200 == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 12),
                        int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4);
            if ($urandom_range(0, 299) == 0) arm = 1'b0;
            else if ($urandom_range(0, 3) == 0) arm = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 49) == 0)
                    x = int'($urandom_range(0, 4095)) - 2048;
                else
                    x = clamp(x + int'($urandom_range(0, 40)) - 12);
                if (x >= XMAX - 50) x = XMIN + 100;
                en_sample   = 1'b1;
                sample_data = DW'(x);
            end else begin
                en_sample = 1'b0;
            end
            tick();
        end
        arm = 1'b1;
        idle(HOLD + BLANK + 10);
        chk("drain_dq", dq.size(), 0);
        chk("drain_nq", nq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_neck_detector
`default_nettype wire

// File: doc/neck_detector.md
# neck_detector

Parametrised successor to the fixed neck-judge stage of the welder control chain. It takes filtered samples, builds saturated 1st/2nd/3rd-order differences, and qualifies a neck event against runtime thresholds in a selectable mode. A qualified event requires N consecutive hits. It then drives a timed power cut followed by a blanking window. It sits between the Kalman filter output and the welder power-switch pin and replaces the separate differentiator and judge stages.

## Interface
Parameters:
- DATA_W, 12, sample and difference width (signed)
- CONFIRM_N, 3, consecutive qualifying samples needed to declare a neck (≥1)
- HOLD_CYCLES, 100000, clocks power_switch is held low per event (≥1)
- BLANK_CYCLES, 50000, clocks after hold during which judging is suppressed (≥1)

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst_n  in  1  reset; asynchronous, active-low
- en_sample  in  1  one-cycle strobe; sample_data valid
- sample_data  in  DATA_W  filtered sample, signed
- arm  in  1  level; 1 = detection enabled
- mode  in  2  00: d1 only; 01: d1&d2; 10/11: d1&d2&d3
- thr1, thr2, thr3  in  DATA_W each  signed thresholds
- d1, d2, d3  out  DATA_W each  registered differences
- dif_valid  out  1  one-cycle pulse; d1..d3 updated
- neck_flag  out  1  one-cycle pulse on neck declaration
- power_switch  out  1  1 = welder power on
- state  out  2  FSM state (debug)
- neck_count  out  16  saturating event count (see Configuration)

## Operation
- Reset values: d1/d2/d3 = 0, dif_valid = 0, neck_flag = 0, power_switch = 1, state = IDLE, neck_count = 0, fill = 0, hit = 0, timer = 0.
- Differences:
  - d1 = x[n] − x[n−1]; d2 = d1[n] − d1[n−1]; d3 = d2[n] − d2[n−1].
  - Each is computed at DATA_W+1 bits and saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - The saturated value is the one stored and reused as history.
- Fill counter saturates at 4. Judging happens only when en_sample arrives with fill = 4 (the 5th sample onward uses full history).
- History and differences update on every en_sample in every state.
- Qualify: signed strict compare per mode: (d1>thr1), plus (d2>thr2), plus (d3>thr3), using the newly computed differences.
- Hit counter:
  - A judged qualifying sample increments it, saturating at CONFIRM_N.
  - A judged failing sample clears it.
  - Non-judged samples leave it unchanged.
- FSM (arm=0 overrides all; IDLE is entered on the next edge):
  - IDLE: power_switch=1, hit=0. Goes to MONITOR when arm=1.
  - MONITOR: judge samples. When hit reaches CONFIRM_N: go to CUT, pulse neck_flag, set power_switch=0, load timer.
  - CUT: power_switch=0. Go to BLANK after HOLD_CYCLES clocks; power_switch returns to 1.
  - BLANK: power_switch=1, no judging, hit held at 0. Go to MONITOR after BLANK_CYCLES clocks.
- arm dropping mid-CUT restores power_switch=1 on the next edge and clears the timer and hit counter.

## Timing
- en_sample at edge T → d1..d3 and dif_valid at T+1.
- Judge result, neck_flag and power_switch fall at T+2.
- Samples with en_sample asserted on consecutive clocks are supported: full throughput, 1 sample/clock.
- CUT lasts exactly HOLD_CYCLES clocks (power_switch low for HOLD_CYCLES cycles); BLANK lasts exactly BLANK_CYCLES clocks.
- Timer width = $clog2(max(HOLD_CYCLES, BLANK_CYCLES)+1).
- Asynchronous reset mid-CUT forces power_switch=1 immediately.

## Configuration
- NECK_DET_STATS_EN defined: neck_count increments on each neck_flag, saturating at 16'hFFFF; cleared only by reset.
- Not defined: neck_count is tied to 0 and the counter logic is absent.

## Structure
- Package neck_pkg:
  - state enum IDLE=0, MONITOR=1, CUT=2, BLANK=3
  - mode encodings
  - saturate function
- Sub-module neck_dif_sat: 3-stage saturated difference chain with fill counter and dif_valid. neck_detector holds the judge, hit counter, FSM, timer and stats.

## Test plan
- Constant sample 100, arm=1, thr1=0, mode=00 → d1..d3 = 0 after fill, no neck_flag, power_switch stays 1.
- Ramp step +10/sample, thr1=5, mode=00, CONFIRM_N=3 → neck_flag on the 7th sample (3rd judged) at T+2, power_switch low for exactly HOLD_CYCLES clocks, then BLANK for BLANK_CYCLES, then MONITOR.
- Samples x=n², thr1=0, thr2=1, mode=01 → d2=2 qualifies and a neck is declared. Repeat with thr2=2 → no neck.
- Sample −2048 then 2047 (DATA_W=12) → d1 saturates to 2047, not wrapped.
- Qualifying pattern interrupted by one failing judged sample after 2 hits → hit cleared; neck only after 3 further consecutive hits.
- arm dropped during CUT → power_switch=1 on the next edge and state=IDLE. Re-arm gives MONITOR with hit=0. With NECK_DET_STATS_EN, neck_count=1.
